// File: rtl/sample_capture.sv
// Triggered sample recorder: on a rising crossing of `level`, stores `length`
// consecutive strobed samples into an internal RAM with a synchronous read port.
module sample_capture #(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [D_WIDTH-1:0] din,
    input  logic [D_WIDTH-1:0] level,
    input  logic [A_WIDTH-1:0] length,
    input  logic               arm,
    input  logic [A_WIDTH-1:0] rd_addr,
    output logic [D_WIDTH-1:0] rd_data,
    output logic               armed,
    output logic               capturing,
    output logic               done,
    output logic [A_WIDTH-1:0] wr_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [1:0]         state, state_nx;
    logic [A_WIDTH-1:0] length_q, count_nx, count_inc;
    logic [D_WIDTH-1:0] prev;
    logic               prev_valid, trig, we;
    logic [D_WIDTH-1:0] mem [0:(2**A_WIDTH)-1];

    always_comb begin
        trig      = en & prev_valid & (prev < level) & (din >= level);
        count_inc = wr_count + A_WIDTH'(1);
        state_nx  = state;
        count_nx  = wr_count;
        we        = 1'b0;
        if (arm) begin
            state_nx = ARMED;
            count_nx = '0;
        end else if ((state == ARMED && trig) || (state == CAPTURE && en)) begin
            // Address-width wrap makes length_q==0 complete after 2**A_WIDTH writes.
            we       = 1'b1;
            count_nx = count_inc;
            state_nx = (count_inc == length_q) ? DONE : CAPTURE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_count   <= '0;
            length_q   <= '0;
            prev       <= '0;
            prev_valid <= 1'b0;
            armed      <= 1'b0;
            capturing  <= 1'b0;
            done       <= 1'b0;
            rd_data    <= '0;
        end else begin
            state     <= state_nx;
            wr_count  <= count_nx;
            armed     <= (state_nx == ARMED);
            capturing <= (state_nx == CAPTURE);
            done      <= (state_nx == DONE);
            rd_data   <= mem[rd_addr];
            if (arm)
                length_q <= length;
            if (en)
                prev <= din;
            if (arm)
                prev_valid <= 1'b0;
            else if (en)
                prev_valid <= 1'b1;
        end
    end

    // RAM contents survive reset; read-before-write falls out of the NBA ordering.
    always_ff @(posedge clk) begin
        if (we)
            mem[wr_count] <= din;
    end

endmodule

// File: tb/tb_sample_capture.sv
// Self-checking bench for sample_capture: directed scenarios plus random
// stimulus, checked every cycle against a count-based behavioural model.
module tb_sample_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       arm = 1'b0;
    logic [7:0] din = '0;
    logic [7:0] level = '0;
    logic [7:0] length = '0;
    logic [7:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       armed, capturing, done;
    logic [7:0] wr_count;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    sample_capture #(.A_WIDTH(8), .D_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .level(level),
        .length(length), .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data),
        .armed(armed), .capturing(capturing), .done(done), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: counts samples written against a target of 1..256.
    logic [7:0] mmem [256];
    bit         mknown [256];
    bit         m_armed = 0, m_cap = 0, m_done = 0, m_pv = 0, m_trig;
    int         m_cnt = 0, m_target = 0, m_prev = 0;
    logic [7:0] exp_rd = '0;
    bit         exp_rd_ok = 1'b1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_armed = 0; m_cap = 0; m_done = 0; m_pv = 0;
            m_cnt = 0; m_prev = 0; exp_rd = '0; exp_rd_ok = 1'b1;
        end else begin
            exp_rd_ok = mknown[rd_addr];
            exp_rd    = mmem[rd_addr];
            m_trig    = en && m_pv && (m_prev < int'(level)) && (int'(din) >= int'(level));
            if (arm) begin
                m_armed = 1; m_cap = 0; m_done = 0; m_cnt = 0;
                m_target = (length == 0) ? 256 : int'(length);
            end else if ((m_armed && m_trig) || (m_cap && en)) begin
                mmem[m_cnt]   = din;
                mknown[m_cnt] = 1'b1;
                m_cnt++;
                m_armed = 0;
                m_cap   = (m_cnt != m_target);
                m_done  = (m_cnt == m_target);
            end
            if (en) begin
                m_prev = int'(din);
                m_pv   = !arm;
            end else if (arm) begin
                m_pv = 0;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("armed", int'(armed), int'(m_armed));
            check("capturing", int'(capturing), int'(m_cap));
            check("done", int'(done), int'(m_done));
            check("wr_count", int'(wr_count), m_cnt % 256);
            if (exp_rd_ok)
                check("rd_data", int'(rd_data), int'(exp_rd));
        end
    end

    task automatic step(input bit a, input bit e, input logic [7:0] d);
        arm = a; en = e; din = d;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rd_data"}, int'(rd_data), 0);
        check({tag, "_wr_count"}, int'(wr_count), 0);
        check({tag, "_armed"}, int'(armed), 0);
        check({tag, "_capturing"}, int'(capturing), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int vals [7] = '{100, 120, 130, 140, 150, 160, 170};
        int gap_exp [4] = '{200, 210, 220, 230};

        repeat (3) @(posedge clk);
        #1;
        chk_on = 1'b1;
        check_zero("reset");
        rst = 1'b1;
        step(0, 0, 0);

        // Basic capture
        level = 8'd128; length = 8'd4;
        step(1, 0, 0);
        check("basic_armed", int'(armed), 1);
        for (int i = 0; i < 7; i++) begin
            step(0, 1, 8'(vals[i]));
            if (vals[i] == 160) begin
                check("basic_done", int'(done), 1);
                check("basic_count", int'(wr_count), 4);
            end
        end
        check("basic_count_after", int'(wr_count), 4);
        check("model_count", m_cnt, 4);
        rd_addr = 8'd2;
        step(0, 0, 0);
        check("basic_read2", int'(rd_data), 150);

        // No false trigger while din stays above level
        step(1, 0, 0);
        repeat (5) step(0, 1, 200);
        check("nofalse_armed", int'(armed), 1);
        check("nofalse_count", int'(wr_count), 0);
        step(0, 1, 50);
        check("nofalse_armed2", int'(armed), 1);
        step(0, 1, 200);
        check("nofalse_cap", int'(capturing), 1);
        check("nofalse_count1", int'(wr_count), 1);
        repeat (3) step(0, 1, 201);

        // Strobe gaps
        step(1, 0, 0);
        step(0, 1, 10);
        step(0, 1, 200);
        step(0, 0, 0);
        step(0, 1, 210);
        step(0, 0, 0);
        step(0, 1, 220);
        step(0, 1, 230);
        check("gap_done", int'(done), 1);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 8'(i);
            step(0, 0, 0);
            check("gap_read", int'(rd_data), gap_exp[i]);
        end

        // Full depth
        length = 8'd0;
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 255);
        for (int i = 1; i < 256; i++) begin
            if (i == 255) check("full_cap_last", int'(capturing), 1);
            step(0, 1, 8'(i));
        end
        check("full_done", int'(done), 1);
        check("full_count", int'(wr_count), 0);
        for (int i = 0; i < 256; i++) begin
            rd_addr = 8'(i);
            step(0, 0, 0);
            check("full_read", int'(rd_data), (i == 0) ? 255 : i);
        end

        // Re-arm mid capture, in the same cycle as a valid strobe
        length = 8'd4;
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 200);
        step(0, 1, 201);
        check("rearm_count2", int'(wr_count), 2);
        step(1, 1, 202);
        check("rearm_armed", int'(armed), 1);
        check("rearm_count0", int'(wr_count), 0);
        check("rearm_cap", int'(capturing), 0);
        step(0, 1, 0);
        step(0, 1, 150);
        check("rearm_cap2", int'(capturing), 1);
        check("rearm_count1", int'(wr_count), 1);
        rd_addr = 8'd2;
        step(0, 0, 0);
        check("rearm_nowrite", int'(rd_data), 2);
        rd_addr = 8'd0;
        step(0, 0, 0);
        check("rearm_addr0", int'(rd_data), 150);

        // Read/write collision on address 1
        step(1, 0, 0);
        rd_addr = 8'd1;
        step(0, 1, 0);
        step(0, 1, 200);
        step(0, 1, 77);
        check("collide_old", int'(rd_data), 201);
        step(0, 0, 0);
        check("collide_new", int'(rd_data), 77);

        // Asynchronous reset mid capture; RAM retained
        step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 200);
        step(0, 1, 99);
        rst = 1'b0;
        #1;
        check_zero("async");
        step(0, 0, 0);
        rst = 1'b1;
        rd_addr = 8'd1;
        step(0, 0, 0);
        check("retain_addr1", int'(rd_data), 99);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) level = 8'($urandom);
            length = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 8));
            rd_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
                #1;
                check_zero("rand_async");
                step(0, 0, 0);
                rst = 1'b1;
            end
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
